weight_load_sched: RTL

WEIGHT_LOAD_SCHED -- requirements
Module: weight_load_sched

---
 rtl/weight_load_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/weight_load_sched.sv
// Double-buffered weight-tile load scheduler: fills two banks ahead of the compute engine
// and hands them over in load order. Optional watchdog on the writer enabled by WLS_TIMEOUT_EN.
module weight_load_sched #(
  parameter int TILE_W      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [2:0]        layer_num,
  input  logic [TILE_W-1:0] tiles_per_layer,
  output logic              wr_start,
  output logic [2:0]        wr_layer,
  output logic              wr_bank,
  input  logic              wr_done,
  input  logic              cmp_req,
  input  logic              cmp_release,
  output logic              cmp_grant,
  output logic              cmp_bank,
  output logic [2:0]        cmp_layer,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [1:0] B_EMPTY   = 2'd0;
  localparam logic [1:0] B_LOADING = 2'd1;
  localparam logic [1:0] B_FULL    = 2'd2;
  localparam logic [1:0] B_INUSE   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_bank_st    [2];
  logic [2:0]        r_bank_layer [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [TILE_W-1:0] r_tiles;
  logic [TILE_W-1:0] r_tile_cnt;
  logic [2:0]        r_layers;
  logic [2:0]        r_layer_cnt;

  logic w_active;
  logic w_inuse;
  logic w_timeout;
  logic w_grant_fire;
  logic w_rel_fire;
  logic w_last_tile;
  logic w_last_layer;
  logic w_drain_done;

  // Only the rd_ptr bank can ever be INUSE, since grants and releases follow load order.
  assign w_active     = (r_state != S_IDLE);
  assign w_inuse      = (r_bank_st[0] == B_INUSE) || (r_bank_st[1] == B_INUSE);
  assign w_grant_fire = w_active && !w_timeout && cmp_req && !w_inuse &&
                        (r_bank_st[r_rd_ptr] == B_FULL);
  assign w_rel_fire   = w_active && !w_timeout && cmp_release && w_inuse;
  assign w_last_tile  = (r_tile_cnt == r_tiles - TILE_W'(1));
  assign w_last_layer = (r_layer_cnt == r_layers - 3'd1);
  assign w_drain_done = (r_state == S_DRAIN) && w_rel_fire &&
                        (r_bank_st[~r_rd_ptr] == B_EMPTY);
  assign dbg_state    = r_state;

`ifdef WLS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = (r_state == S_WAIT) && !wr_done && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign err       = r_err;

  // Counter sits at zero outside WAIT, so each WAIT entry starts a fresh window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err    <= w_timeout;
      r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt + TO_W'(1) : '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_tiles     <= '0;
      r_tile_cnt  <= '0;
      r_layers    <= '0;
      r_layer_cnt <= '0;
      wr_start    <= 1'b0;
      wr_layer    <= '0;
      wr_bank     <= 1'b0;
      cmp_grant   <= 1'b0;
      cmp_bank    <= 1'b0;
      cmp_layer   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_bank_st[i]    <= B_EMPTY;
        r_bank_layer[i] <= '0;
      end
    end else begin
      wr_start  <= 1'b0;
      cmp_grant <= 1'b0;
      done      <= 1'b0;

      if (w_grant_fire) begin
        cmp_grant            <= 1'b1;
        cmp_bank             <= r_rd_ptr;
        cmp_layer            <= r_bank_layer[r_rd_ptr];
        r_bank_st[r_rd_ptr]  <= B_INUSE;
      end
      if (w_rel_fire) begin
        r_bank_st[r_rd_ptr] <= B_EMPTY;
        r_rd_ptr            <= ~r_rd_ptr;
      end

      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_layers    <= (layer_num == 3'd0) ? 3'd1 : layer_num;
            r_tiles     <= (tiles_per_layer == '0) ? TILE_W'(1) : tiles_per_layer;
            r_tile_cnt  <= '0;
            r_layer_cnt <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_bank_st[r_wr_ptr] == B_EMPTY) begin
            wr_start               <= 1'b1;
            wr_layer               <= r_layer_cnt;
            wr_bank                <= r_wr_ptr;
            r_bank_st[r_wr_ptr]    <= B_LOADING;
            r_bank_layer[r_wr_ptr] <= r_layer_cnt;
            r_state                <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wr_done) begin
            r_bank_st[r_wr_ptr] <= B_FULL;
            r_wr_ptr            <= ~r_wr_ptr;
            r_state             <= S_ISSUE;
            if (!w_last_tile) begin
              r_tile_cnt <= r_tile_cnt + TILE_W'(1);
            end else begin
              r_tile_cnt <= '0;
              if (w_last_layer) r_state <= S_DRAIN;
              else              r_layer_cnt <= r_layer_cnt + 3'd1;
            end
          end else if (w_timeout) begin
            r_bank_st[0] <= B_EMPTY;
            r_bank_st[1] <= B_EMPTY;
            busy         <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          if (w_drain_done) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
